// File: rtl/multiplexor_display_7seg_pkg.sv
// -----------------------------------------------------------------------------
// multiplexor_display_7seg_pkg
// Shared definitions for the multiplexed 4-digit 7-segment display driver:
// active-low segment patterns (bit 6 = a ... bit 0 = g), the all-off anode
// word, default timing parameters, the captured-digit record and small
// helpers for anode selection and leading-zero suppression.
// -----------------------------------------------------------------------------
package multiplexor_display_7seg_pkg;

  // Default timing: 1 ms per digit slot at 50 MHz, two dark cycles per slot.
  localparam int DIV_REFRESCO_DEF = 50000;
  localparam int GUARDA_DEF       = 2;

  // Active-low segment patterns, bit 6 = a through bit 0 = g.
  localparam logic [6:0] SEG_0    = 7'b0000001;
  localparam logic [6:0] SEG_1    = 7'b1001111;
  localparam logic [6:0] SEG_2    = 7'b0010010;
  localparam logic [6:0] SEG_3    = 7'b0000110;
  localparam logic [6:0] SEG_4    = 7'b1001100;
  localparam logic [6:0] SEG_5    = 7'b0100100;
  localparam logic [6:0] SEG_6    = 7'b0100000;
  localparam logic [6:0] SEG_7    = 7'b0001111;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0000100;
  localparam logic [6:0] SEG_DASH = 7'b1111110;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  // Active-low anodes: all digits dark.
  localparam logic [3:0] ANODOS_OFF = 4'b1111;

  // Digit slot index; the value is also the anode bit position.
  typedef enum logic [1:0] {
    DIG_UNIDADES = 2'd0,
    DIG_DECENAS  = 2'd1,
    DIG_CENTENAS = 2'd2,
    DIG_MILLARES = 2'd3
  } digito_e;

  // Shadow copy of the inputs, frozen for a whole scan frame.
  typedef struct packed {
    logic [3:0] millares;
    logic [3:0] centenas;
    logic [3:0] decenas;
    logic [3:0] unidades;
    logic       blanqueo;
  } sombra_t;

  localparam sombra_t SOMBRA_RST = sombra_t'(17'd0);

  // Active-low one-hot anode word for a digit slot.
  function automatic logic [3:0] anodo_activo(input logic [1:0] idx);
    logic [3:0] an;
    case (idx)
      DIG_UNIDADES: an = 4'b1110;
      DIG_DECENAS:  an = 4'b1101;
      DIG_CENTENAS: an = 4'b1011;
      DIG_MILLARES: an = 4'b0111;
      default:      an = ANODOS_OFF;
    endcase
    return an;
  endfunction

  // Leading-zero suppression: a digit is blanked only when every more
  // significant digit (and itself) is zero. Codes 10-15 are nonzero, so an
  // invalid upper digit keeps the zeros below it visible. Units never blank.
  function automatic logic digito_blanco(input sombra_t s, input logic [1:0] idx);
    logic m0;
    logic c0;
    logic d0;
    logic b;
    m0 = (s.millares == 4'd0);
    c0 = (s.centenas == 4'd0);
    d0 = (s.decenas  == 4'd0);
    case (idx)
      DIG_MILLARES: b = s.blanqueo & m0;
      DIG_CENTENAS: b = s.blanqueo & m0 & c0;
      DIG_DECENAS:  b = s.blanqueo & m0 & c0 & d0;
      default:      b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/multiplexor_display_7seg_decodificador.sv
// -----------------------------------------------------------------------------
// decodificador_bcd_7seg
// Purely combinational BCD to 7-segment decoder with active-low outputs.
// Codes 10-15 show a dash so a bad converter output is visible on the panel.
//
// Ports:
//   bcd        in   4  BCD digit
//   segmentos  out  7  active-low segments, bit 6 = a ... bit 0 = g
// -----------------------------------------------------------------------------
module decodificador_bcd_7seg
  import multiplexor_display_7seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] segmentos
);

  // Pattern lookup; anything outside 0-9 falls to the dash.
  always_comb begin
    segmentos = SEG_DASH;
    case (bcd)
      4'd0:    segmentos = SEG_0;
      4'd1:    segmentos = SEG_1;
      4'd2:    segmentos = SEG_2;
      4'd3:    segmentos = SEG_3;
      4'd4:    segmentos = SEG_4;
      4'd5:    segmentos = SEG_5;
      4'd6:    segmentos = SEG_6;
      4'd7:    segmentos = SEG_7;
      4'd8:    segmentos = SEG_8;
      4'd9:    segmentos = SEG_9;
      default: segmentos = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/multiplexor_display_7seg.sv
// -----------------------------------------------------------------------------
// multiplexor_display_7seg
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// A prescaler holds each digit slot for DIV_REFRESCO cycles; the first GUARDA
// cycles of every slot keep all anodes dark to avoid ghosting. The digits
// are sampled into a shadow register once per frame (at the wrap out of the
// millares slot, and on the first clock after reset) so a frame never mixes
// old and new digits. Anodes and segments are registered (latency 1).
//
// Ports:
//   clk        in   1  system clock
//   reset_n    in   1  asynchronous active-low reset
//   unidades   in   4  BCD units digit
//   decenas    in   4  BCD tens digit
//   centenas   in   4  BCD hundreds digit
//   millares   in   4  BCD thousands digit
//   blanqueo   in   1  1 = suppress leading zeros
//   anodos     out  4  active-low digit enables, bit 0 = unidades
//   segmentos  out  7  active-low segments, bit 6 = a ... bit 0 = g
//   fin_trama  out  1  one-cycle pulse after new digits are captured
// -----------------------------------------------------------------------------
module multiplexor_display_7seg
  import multiplexor_display_7seg_pkg::*;
#(
  parameter int DIV_REFRESCO = DIV_REFRESCO_DEF,
  parameter int GUARDA       = GUARDA_DEF
)
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] unidades,
  input  logic [3:0] decenas,
  input  logic [3:0] centenas,
  input  logic [3:0] millares,
  input  logic       blanqueo,
  output logic [3:0] anodos,
  output logic [6:0] segmentos,
  output logic       fin_trama
);

  localparam int              CW         = (DIV_REFRESCO > 1) ? $clog2(DIV_REFRESCO) : 1;
  localparam logic [CW-1:0]   CNT_MAX    = CW'(DIV_REFRESCO - 1);
  localparam logic [CW-1:0]   CNT_GUARDA = CW'(GUARDA);

  logic [CW-1:0] cnt_r;
  logic [1:0]    idx_r;
  logic          primera_r;
  sombra_t       sombra_r;
  logic          fin_trama_r;
  logic [3:0]    anodos_r;
  logic [6:0]    segmentos_r;

  logic          wrap_s;
  logic          captura_s;
  sombra_t       entrada_s;
  logic [3:0]    digito_s;
  logic [6:0]    patron_s;
  logic          blanco_s;
  logic [3:0]    anodos_nxt_s;
  logic [6:0]    segmentos_nxt_s;

  assign wrap_s    = (cnt_r == CNT_MAX);
  // Capture at the millares -> unidades wrap, or right after reset so the
  // first frame never shows the cleared shadow.
  assign captura_s = primera_r | (wrap_s & (idx_r == DIG_MILLARES));
  assign entrada_s = {millares, centenas, decenas, unidades, blanqueo};

  // Slot prescaler and digit index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CW{1'b0}};
      idx_r <= DIG_UNIDADES;
    end else if (wrap_s) begin
      cnt_r <= {CW{1'b0}};
      idx_r <= idx_r + 2'd1;
    end else begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      idx_r <= idx_r;
    end
  end

  // Marks the first clock after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      primera_r <= 1'b1;
    end else begin
      primera_r <= 1'b0;
    end
  end

  // Shadow register and frame pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sombra_r    <= SOMBRA_RST;
      fin_trama_r <= 1'b0;
    end else if (captura_s) begin
      sombra_r    <= entrada_s;
      fin_trama_r <= 1'b1;
    end else begin
      sombra_r    <= sombra_r;
      fin_trama_r <= 1'b0;
    end
  end

  // Select the shadow digit for the current slot.
  always_comb begin
    digito_s = sombra_r.unidades;
    case (idx_r)
      DIG_UNIDADES: digito_s = sombra_r.unidades;
      DIG_DECENAS:  digito_s = sombra_r.decenas;
      DIG_CENTENAS: digito_s = sombra_r.centenas;
      DIG_MILLARES: digito_s = sombra_r.millares;
      default:      digito_s = sombra_r.unidades;
    endcase
  end

  decodificador_bcd_7seg u_decodificador (
    .bcd       (digito_s),
    .segmentos (patron_s)
  );

  assign blanco_s = digito_blanco(sombra_r, idx_r);

  // Next anode/segment values: dark during the guard window, otherwise the
  // selected digit, with a blanked digit keeping its anode but no segments.
  always_comb begin
    anodos_nxt_s    = ANODOS_OFF;
    segmentos_nxt_s = SEG_OFF;
    if (cnt_r < CNT_GUARDA) begin
      anodos_nxt_s    = ANODOS_OFF;
      segmentos_nxt_s = SEG_OFF;
    end else begin
      anodos_nxt_s = anodo_activo(idx_r);
      if (blanco_s) begin
        segmentos_nxt_s = SEG_OFF;
      end else begin
        segmentos_nxt_s = patron_s;
      end
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      anodos_r    <= ANODOS_OFF;
      segmentos_r <= SEG_OFF;
    end else begin
      anodos_r    <= anodos_nxt_s;
      segmentos_r <= segmentos_nxt_s;
    end
  end

  assign anodos    = anodos_r;
  assign segmentos = segmentos_r;
  assign fin_trama = fin_trama_r;

endmodule

// File: tb/tb_multiplexor_display_7seg.sv
// Scoreboard bench: the stimulus side pushes the four expected digit slots of
// every frame it programs; a monitor pops one entry at the start of each lit
// slot and also checks guard length, slot length and one fin_trama per frame.
module tb_multiplexor_display_7seg;

  localparam int DIV    = 4;
  localparam int GUARDA = 1;
  localparam int NFR    = 18;
  localparam int RST_FR = 9;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] unidades = 4'd0, decenas = 4'd0, centenas = 4'd0, millares = 4'd0;
  logic       blanqueo = 1'b0;
  logic [3:0] anodos;
  logic [6:0] segmentos;
  logic       fin_trama;

  multiplexor_display_7seg #(.DIV_REFRESCO(DIV), .GUARDA(GUARDA)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .unidades  (unidades),
    .decenas   (decenas),
    .centenas  (centenas),
    .millares  (millares),
    .blanqueo  (blanqueo),
    .anodos    (anodos),
    .segmentos (segmentos),
    .fin_trama (fin_trama)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] an; logic [6:0] seg; } slot_t;
  typedef struct { logic [3:0] m, c, d, u; logic b; } frame_t;

  slot_t  exp_q[$];
  frame_t frames[NFR];
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference segment table written from the digit shapes.
  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    logic [6:0] tbl [0:9];
    tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    if (v > 4'd9) return 7'b1111110;
    return tbl[v];
  endfunction

  // Expected slots 0..3: with blanking on, every position above the most
  // significant nonzero digit is dark; position 0 is always shown.
  function automatic void push_frame(input frame_t f);
    logic [3:0] dig [0:3];
    int         top;
    slot_t      s;
    dig[0] = f.u; dig[1] = f.d; dig[2] = f.c; dig[3] = f.m;
    top = 0;
    for (int i = 0; i < 4; i++) if (dig[i] != 4'd0) top = i;
    for (int i = 0; i < 4; i++) begin
      s.an    = 4'b1111;
      s.an[i] = 1'b0;
      s.seg   = (f.b && i > top) ? 7'b1111111 : ref_seg(dig[i]);
      exp_q.push_back(s);
    end
  endfunction

  task automatic apply_frame(input frame_t f);
    millares = f.m; centenas = f.c; decenas = f.d; unidades = f.u; blanqueo = f.b;
  endtask

  function automatic logic [3:0] rnd_digit();
    if ($urandom_range(0, 1) == 0) return 4'd0;
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic wait_fin(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fin_trama === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL fin_trama wait: no pulse within 40 cycles (t=%0t)", $time);
  endtask

  // Monitor: one scoreboard pop per lit slot.
  initial begin
    int    off_run;
    int    act_run;
    int    fin_seen;
    logic [3:0] cur_an;
    slot_t e;
    off_run = 0; act_run = 0; fin_seen = 0; cur_an = 4'b1111;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        off_run = 0; act_run = 0; fin_seen = 0;
      end else begin
        if (fin_trama === 1'b1) fin_seen++;
        if (anodos === 4'b1111) begin
          if (act_run > 0) check("slot length", act_run, DIV - GUARDA);
          act_run = 0;
          off_run++;
        end else if (act_run == 0) begin
          check("guard length", off_run, GUARDA);
          off_run = 0;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: unexpected slot anodos=%b segmentos=%b", anodos, segmentos);
          end else begin
            e = exp_q.pop_front();
            check("slot anodos", anodos, e.an);
            check("slot segmentos", segmentos, e.seg);
            cur_an = e.an;
          end
          if (anodos === 4'b1110) begin
            check("fin_trama cycles per frame", fin_seen, 1);
            fin_seen = 0;
          end
          act_run = 1;
        end else begin
          check("anodos steady in slot", anodos, cur_an);
          act_run++;
        end
      end
    end
  end

  // Stimulus.
  initial begin
    bit ok;
    int w;
    frames[0] = '{4'd1, 4'd2, 4'd3, 4'd4, 1'b0};
    frames[1] = '{4'd0, 4'd0, 4'd0, 4'd7, 1'b1};
    frames[2] = '{4'd0, 4'd0, 4'd5, 4'd0, 1'b1};
    frames[3] = '{4'd0, 4'd0, 4'd0, 4'hC, 1'b0};
    frames[4] = '{4'hA, 4'd0, 4'd0, 4'd0, 1'b1};
    for (int i = 5; i < NFR; i++)
      frames[i] = '{rnd_digit(), rnd_digit(), rnd_digit(), rnd_digit(), 1'($urandom_range(0, 1))};

    apply_frame(frames[0]);
    repeat (2) @(negedge clk);
    check("reset anodos", anodos, 4'b1111);
    check("reset segmentos", segmentos, 7'b1111111);
    check("reset fin_trama", fin_trama, 1'b0);
    push_frame(frames[0]);
    #2 reset_n = 1'b1;

    for (int f = 0; f < NFR; f++) begin
      wait_fin(ok);
      if (!ok) break;
      if (f == NFR - 1) break;
      if (f == RST_FR) begin
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
          @(negedge clk);
          if (anodos === 4'b1011) ok = 1'b1;
        end
        if (!ok) begin
          n_checks++;
          n_fail++;
          $display("FAIL centenas slot wait: not reached within 20 cycles");
          break;
        end
        #2 reset_n = 1'b0;
        #1;
        check("async reset anodos", anodos, 4'b1111);
        check("async reset segmentos", segmentos, 7'b1111111);
        check("async reset fin_trama", fin_trama, 1'b0);
        exp_q.delete();
        apply_frame(frames[f + 1]);
        push_frame(frames[f + 1]);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
      end else begin
        w = $urandom_range(1, 15);
        repeat (w) @(negedge clk);
        apply_frame(frames[f + 1]);
        push_frame(frames[f + 1]);
      end
    end

    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/multiplexor_display_7seg.md
MULTIPLEXOR_DISPLAY_7SEG -- requirements
Module: multiplexor_display_7seg

Interface
REQ-001 Parameter DIV_REFRESCO, default 50000: clock cycles each digit slot is held (1 ms at 50 MHz).
REQ-002 Parameter GUARDA, default 2: cycles at the start of each slot with all anodes off (anti-ghosting); legal range 0 to DIV_REFRESCO-1.
REQ-003 Ports: one clock; reset is asynchronous and active-low (clk, reset_n).
REQ-004 clk  input  1  system clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 unidades, decenas, centenas, millares  input  4 each  BCD digits from the binary-to-BCD converter.
REQ-007 blanqueo  input  1  1 = suppress leading zeros.
REQ-008 anodos  output  4  digit enables, active-low; bit 0 = unidades, bit 3 = millares.
REQ-009 segmentos  output  7  active-low segments; bit 6 = a through bit 0 = g.
REQ-010 fin_trama  output  1  one-cycle pulse when new digits are captured.

Function
REQ-011 The prescaler shall count 0 to DIV_REFRESCO-1 and wrap; on wrap, the 2-bit digit index shall advance 0,1,2,3,0.
REQ-012 The four input digits plus blanqueo shall be captured into a shadow register only on the wrap cycle where the index is 3, and on the first clock after reset deassertion; inputs shall not affect the display otherwise (no tearing).
REQ-013 fin_trama shall be high for exactly the cycle following each capture.
REQ-014 anodos and segmentos shall be registered; each cycle they reflect the index and prescaler values from the previous cycle (latency 1).
REQ-015 When the prescaler is below GUARDA, anodos shall be 4'b1111; otherwise exactly one anode bit, the current index, shall be 0.
REQ-016 BCD 0-9 shall decode to standard patterns (0 = 7'b0000001, 8 = 7'b0000000); codes 10-15 shall display a dash (7'b1111110).
REQ-017 With shadow blanqueo = 1: millares is blanked if 0; centenas if millares and centenas are both 0; decenas if the upper three digits are all 0; unidades is never blanked.
REQ-018 A blanked digit shall drive segmentos 7'b1111111 while its anode remains active; an invalid code (10-15) counts as nonzero for blanking.
REQ-019 Inputs changing on the capture cycle shall be captured with the values present on that edge.

Reset
REQ-020 While reset_n = 0: prescaler 0, index 0, shadow 0, anodos 4'b1111, segmentos 7'b1111111, fin_trama 0.
REQ-021 Asserting reset mid-slot shall return all outputs to the REQ-020 values asynchronously; the first capture after release shall follow REQ-012.

Structure
REQ-022 A shared package shall hold the segment pattern constants (0-9, dash, off), the all-off anode constant, and the default DIV_REFRESCO/GUARDA values.
REQ-023 One combinational sub-module, decodificador_bcd_7seg (4-bit BCD in, 7-bit active-low segments out, dash for 10-15), shall be instantiated once on the selected digit.

Verification (bench DIV_REFRESCO = 4, GUARDA = 1)
REQ-024 Reset release, digits 1,2,3,4, blanqueo 0 -> fin_trama pulses once; slots show unidades 4 (7'b1001100), decenas 3, centenas 2, millares 1; anodos cycle 1110,1101,1011,0111, each preceded by one 1111 cycle.
REQ-025 Digits 0,0,0,7 with blanqueo 1 -> millares, centenas, and decenas slots show 7'b1111111; unidades shows 7 (7'b0001111).
REQ-026 Digits 0,0,5,0 with blanqueo 1 -> millares and centenas are blank; decenas shows 5 and unidades shows 0.
REQ-027 Input digits changed mid-frame -> the display is unchanged until the next index 3 to 0 wrap; fin_trama pulses at that point and new values appear.
REQ-028 Unidades = 4'hC -> dash on the unidades slot; with blanqueo 1 and millares = 4'hA, the lower zeros are not blanked.
REQ-029 reset_n pulsed low during the index 2 slot -> anodos become 1111 immediately; after release, the scan restarts at index 0 with a fresh capture.
